// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// MEM-stage load/store unit: decodes the EX/MEM instruction, runs one
// request/grant/response transaction on the data port and extends load data.
module mem_access_stage #(
  parameter int unsigned addrWidth = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic [31:0]          alu_out,
  input  logic [31:0]          rs2_rdata,
  output logic                 stall,
  output logic [31:0]          ld_data,
  output logic                 ld_valid,
  output logic                 misalign,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [addrWidth-1:0] dmem_addr,
  output logic [31:0]          dmem_wdata,
  output logic [3:0]           dmem_wstrb,
  input  logic                 dmem_gnt,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_rvalid
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic        go;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign off    = alu_out[1:0];

  // Only the listed funct3 encodings count as memory ops; all else passes through.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode == OPC_LOAD) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
        default:                                is_load = 1'b0;
      endcase
    end
    if (opcode == OPC_STORE) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: is_store = 1'b1;
        default:                is_store = 1'b0;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign go = (is_load | is_store) & ~misaligned;

  // IDLE stall is combinational so the instruction is held from its first cycle.
  assign stall = ((state == IDLE) & go) | (state == REQ) | (state == WAIT);

  always_comb begin
    fmt_wdata = rs2_rdata;
    fmt_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        fmt_wdata = {4{rs2_rdata[7:0]}};
        fmt_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        fmt_wdata = {2{rs2_rdata[15:0]}};
        fmt_wstrb = 4'b0011 << off;
      end
      default: begin
        fmt_wdata = rs2_rdata;
        fmt_wstrb = 4'b1111;
      end
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = word;
    endcase
  endfunction

  logic unused_bits;
  assign unused_bits = ^{inst[31:15], inst[11:7], alu_out[31:addrWidth]};

  // Transaction FSM; every port-facing output below is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'd0;
      dmem_wstrb <= 4'd0;
      ld_data    <= 32'd0;
      ld_valid   <= 1'b0;
      misalign   <= 1'b0;
      is_load_q  <= 1'b0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
    end else begin
      ld_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if ((is_load | is_store) & misaligned) begin
            misalign <= 1'b1;
          end else if (go) begin
            is_load_q  <= is_load;
            funct3_q   <= funct3;
            off_q      <= off;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_out[addrWidth-1:2], 2'b00};
            dmem_wdata <= fmt_wdata;
            dmem_wstrb <= is_store ? fmt_wstrb : 4'd0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (!is_load_q) begin
              state <= DONE;
            end else if (dmem_rvalid) begin
              ld_data  <= extract(dmem_rdata, funct3_q, off_q);
              ld_valid <= 1'b1;
              state    <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            ld_data  <= extract(dmem_rdata, funct3_q, off_q);
            ld_valid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
// Directed bench for mem_access_stage: a per-cycle schedule of inputs and expected
// outputs is built from transaction-level rules, then replayed and compared.
module tb_mem_access_stage;

  localparam int unsigned AW = 15;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   inst = 32'd0;
  logic [31:0]   alu_out = 32'd0;
  logic [31:0]   rs2_rdata = 32'd0;
  logic          stall;
  logic [31:0]   ld_data;
  logic          ld_valid;
  logic          misalign;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_wstrb;
  logic          dmem_gnt = 1'b0;
  logic [31:0]   dmem_rdata = 32'd0;
  logic          dmem_rvalid = 1'b0;

  mem_access_stage #(.addrWidth(AW)) dut (
    .clk(clk), .rst(rst), .inst(inst), .alu_out(alu_out), .rs2_rdata(rs2_rdata),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   inst, alu, rs2, rdata;
    logic          gnt, rvalid, rst;
    logic          e_stall, e_req, e_we, e_ldv, e_mis, chk_bus;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata, e_ldd;
    logic [3:0]    e_wstrb;
  } cyc_t;

  cyc_t        sched[$];
  logic [31:0] mem [int];
  int          vectors = 0;
  int          errors = 0;
  logic        pend_mis = 1'b0;
  logic [31:0] m_ldd = 32'd0;
  int          stall_cnt, req_cnt, mis_cnt, ldv_cnt;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  function automatic bit is_ld(input logic [31:0] i);
    logic [2:0] f = i[14:12];
    return (i[6:0] == OP_LD) && (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
  endfunction

  function automatic bit is_st(input logic [31:0] i);
    logic [2:0] f = i[14:12];
    return (i[6:0] == OP_ST) && (f == 3'd0 || f == 3'd1 || f == 3'd2);
  endfunction

  function automatic int nbytes(input logic [31:0] i);
    logic [2:0] f = i[14:12];
    return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit will_go(input logic [31:0] i, input logic [31:0] a);
    return (is_ld(i) || is_st(i)) && ((a % nbytes(i)) == 0);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a & 32'h7FFF) >> 2);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int idx = word_idx(a);
    return mem.exists(idx) ? mem[idx] : 32'd0;
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] w = mem_rd(a);
    for (int b = 0; b < 4; b++)
      if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem[word_idx(a)] = w;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] rd, input logic [2:0] f3, input int off);
    logic [31:0] v = rd >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(v[7:0]));
      3'd1:    return 32'($signed(v[15:0]));
      3'd4:    return v & 32'h0000_00FF;
      3'd5:    return v & 32'h0000_FFFF;
      default: return rd;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [31:0] i, input logic [31:0] a, input logic [31:0] d);
    cyc_t c;
    c.inst = i; c.alu = a; c.rs2 = d; c.rdata = 32'd0;
    c.gnt = 1'b0; c.rvalid = 1'b0; c.rst = 1'b0;
    c.e_stall = 1'b0; c.e_req = 1'b0; c.e_we = 1'b0; c.e_ldv = 1'b0; c.e_mis = 1'b0;
    c.chk_bus = 1'b0; c.e_addr = '0; c.e_wdata = 32'd0; c.e_ldd = m_ldd; c.e_wstrb = 4'd0;
    return c;
  endfunction

  // misalign is a registered pulse: it shows up one cycle after the offending op.
  function automatic void push(input cyc_t c, input bit idle_mis);
    cyc_t t = c;
    t.e_mis = pend_mis;
    pend_mis = idle_mis;
    sched.push_back(t);
  endfunction

  function automatic void reset_cyc(input logic [31:0] i, input logic [31:0] a);
    cyc_t c;
    pend_mis = 1'b0;
    m_ldd = 32'd0;
    c = blank(i, a, 32'd0);
    c.rst = 1'b1;
    c.e_stall = will_go(i, a);
    c.chk_bus = 1'b1;
    push(c, 1'b0);
  endfunction

  // One instruction in the EX/MEM register, with memory grant/response timing.
  function automatic void op(input logic [31:0] i, input logic [31:0] a, input logic [31:0] d,
                             input int gnt_dly, input int rv_dly,
                             input logic [31:0] rforce, input bit use_mem);
    cyc_t c;
    bit ld = is_ld(i);
    bit st = is_st(i);
    int n, off, m;
    logic [31:0] rd;
    c = blank(i, a, d);
    if (!(ld || st)) begin
      push(c, 1'b0);
      return;
    end
    n = nbytes(i);
    off = int'(a % 32'd4);
    if ((a % n) != 0) begin
      push(c, 1'b1);
      return;
    end
    c.e_stall = 1'b1;
    push(c, 1'b0);
    c.e_req = 1'b1; c.chk_bus = 1'b1; c.e_we = st;
    c.e_addr = AW'(a & 32'hFFFF_FFFC);
    m = ((1 << n) - 1) << off;
    c.e_wstrb = st ? 4'(m) : 4'd0;
    c.e_wdata = (n == 1) ? 32'(d[7:0]) * 32'h0101_0101 :
                (n == 2) ? 32'(d[15:0]) * 32'h0001_0001 : d;
    for (int k = 0; k < gnt_dly; k++) push(c, 1'b0);
    rd = use_mem ? mem_rd(a) : rforce;
    c.gnt = 1'b1;
    if (ld && rv_dly == 0) begin
      c.rvalid = 1'b1;
      c.rdata = rd;
    end
    push(c, 1'b0);
    if (st) mem_wr(a, c.e_wdata, c.e_wstrb);
    c.gnt = 1'b0; c.rvalid = 1'b0; c.rdata = 32'd0; c.e_req = 1'b0; c.chk_bus = 1'b0;
    if (ld && rv_dly > 0) begin
      for (int k = 1; k < rv_dly; k++) push(c, 1'b0);
      c.rvalid = 1'b1;
      c.rdata = rd;
      push(c, 1'b0);
      c.rvalid = 1'b0;
      c.rdata = 32'd0;
    end
    c.e_stall = 1'b0;
    if (ld) begin
      m_ldd = ext(rd, i[14:12], off);
      c.e_ldd = m_ldd;
      c.e_ldv = 1'b1;
    end
    push(c, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Replays the schedule: drive just after the rising edge, compare on the falling edge.
  task automatic run();
    cyc_t c;
    stall_cnt = 0; req_cnt = 0; mis_cnt = 0; ldv_cnt = 0;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      @(posedge clk);
      #1;
      rst = c.rst; inst = c.inst; alu_out = c.alu; rs2_rdata = c.rs2;
      dmem_gnt = c.gnt; dmem_rvalid = c.rvalid; dmem_rdata = c.rdata;
      @(negedge clk);
      chk("stall", 32'(stall), 32'(c.e_stall));
      chk("dmem_req", 32'(dmem_req), 32'(c.e_req));
      chk("ld_valid", 32'(ld_valid), 32'(c.e_ldv));
      chk("misalign", 32'(misalign), 32'(c.e_mis));
      chk("ld_data", ld_data, c.e_ldd);
      if (c.chk_bus) begin
        chk("dmem_we", 32'(dmem_we), 32'(c.e_we));
        chk("dmem_addr", 32'(dmem_addr), 32'(c.e_addr));
        chk("dmem_wstrb", 32'(dmem_wstrb), 32'(c.e_wstrb));
        if (c.e_we || c.rst) chk("dmem_wdata", dmem_wdata, c.e_wdata);
      end
      if (stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      if (misalign) mis_cnt++;
      if (ld_valid) ldv_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nop, lb, lh, lw, lbu, lhu, sb, sh, sw, add, ld3;
    nop = mk(3'd0, OP_IMM); add = mk(3'd0, OP_ALU); ld3 = mk(3'd3, OP_LD);
    lb = mk(3'd0, OP_LD); lh = mk(3'd1, OP_LD); lw = mk(3'd2, OP_LD);
    lbu = mk(3'd4, OP_LD); lhu = mk(3'd5, OP_LD);
    sb = mk(3'd0, OP_ST); sh = mk(3'd1, OP_ST); sw = mk(3'd2, OP_ST);

    // reset: stall still follows decode of an aligned memory op
    reset_cyc(lw, 32'h0);
    reset_cyc(nop, 32'h0);
    run();

    // 1: LW with grant now, data one cycle later
    op(lw, 32'h104, 32'd0, 0, 1, 32'hDEAD_BEEF, 1'b0);
    op(nop, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
    run();
    chk("t1_ld_data", ld_data, 32'hDEAD_BEEF);
    chk("t1_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("t1_ld_valid_pulses", 32'(ldv_cnt), 32'd1);

    // 2: byte/halfword extraction
    op(lb, 32'h103, 32'd0, 0, 1, 32'h8012_3456, 1'b0);
    op(nop, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
    run();
    chk("t2_lb", ld_data, 32'hFFFF_FF80);
    op(lbu, 32'h103, 32'd0, 0, 0, 32'h8012_3456, 1'b0);
    run();
    chk("t2_lbu", ld_data, 32'h0000_0080);
    chk("t2_lbu_stall_cycles", 32'(stall_cnt), 32'd2);
    op(lhu, 32'h102, 32'd0, 1, 2, 32'hBEEF_0000, 1'b0);
    op(lh, 32'hABCD_8102, 32'd0, 0, 1, 32'hBEEF_0000, 1'b0);
    run();
    chk("t2_lh", ld_data, 32'hFFFF_BEEF);

    // 5: reset while waiting for read data; late rvalid must be ignored
    begin
      cyc_t c;
      c = blank(lw, 32'h104, 32'd0);
      c.e_stall = 1'b1; push(c, 1'b0);
      c.e_req = 1'b1; c.chk_bus = 1'b1; c.e_addr = AW'(32'h104); c.gnt = 1'b1; push(c, 1'b0);
      c.e_req = 1'b0; c.chk_bus = 1'b0; c.gnt = 1'b0; push(c, 1'b0);
      reset_cyc(nop, 32'd0);
      c = blank(nop, 32'd0, 32'd0); c.rvalid = 1'b1; c.rdata = 32'h55AA_55AA; push(c, 1'b0);
      op(nop, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
      run();
      chk("t5_ld_data", ld_data, 32'd0);
      chk("t5_ld_valid_pulses", 32'(ldv_cnt), 32'd0);
    end

    // 3: SB with grant held off three cycles
    op(sb, 32'h202, 32'h0000_00A5, 3, 0, 32'd0, 1'b1);
    op(nop, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
    run();
    chk("t3_req_cycles", 32'(req_cnt), 32'd4);
    chk("t3_stall_cycles", 32'(stall_cnt), 32'd5);

    // 4: misaligned ops and non-memory ops never request or stall
    op(lh, 32'h101, 32'd0, 0, 0, 32'd0, 1'b0);
    op(nop, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
    op(lw, 32'h102, 32'd0, 0, 0, 32'd0, 1'b0);
    op(add, 32'h100, 32'd0, 0, 0, 32'd0, 1'b0);
    op(sh, 32'h203, 32'h1234, 0, 0, 32'd0, 1'b0);
    op(ld3, 32'h100, 32'd0, 0, 0, 32'd0, 1'b0);
    op(nop, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
    run();
    chk("t4_misalign_pulses", 32'(mis_cnt), 32'd3);
    chk("t4_req_cycles", 32'(req_cnt), 32'd0);
    chk("t4_stall_cycles", 32'(stall_cnt), 32'd0);

    // 6: back-to-back store then load to the same word
    op(sw, 32'h300, 32'h1234_5678, 0, 0, 32'd0, 1'b1);
    op(lw, 32'h300, 32'd0, 0, 0, 32'd0, 1'b1);
    run();
    chk("t6_lw", ld_data, 32'h1234_5678);
    chk("t6_req_cycles", 32'(req_cnt), 32'd2);
    op(sh, 32'h302, 32'h0000_CAFE, 1, 0, 32'd0, 1'b1);
    op(lw, 32'h300, 32'd0, 0, 1, 32'd0, 1'b1);
    run();
    chk("t6_merged_lw", ld_data, 32'hCAFE_5678);
    op(lh, 32'h302, 32'd0, 2, 1, 32'd0, 1'b1);
    op(lbu, 32'h201, 32'd0, 0, 0, 32'd0, 1'b1);
    op(nop, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
    run();
    chk("t6_lbu_after_sb", ld_data, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes the latched instruction, ALU result (effective address) and rs2 data.
- Runs a request/grant/response transaction on the data-memory port and stalls the pipeline until the access completes.
- Produces aligned, sign/zero-extended load data for the MEM/WB register.

Parameters:
addrWidth, 15, byte-address width of the data-memory port (matches pipeline PC width convention)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
inst  input  32  instruction from EX/MEM register
alu_out  input  32  effective byte address from EX/MEM register
rs2_rdata  input  32  store data from EX/MEM register
stall  output  1  pipeline stall request to all upstream stage registers
ld_data  output  32  extended load result to MEM/WB register
ld_valid  output  1  one-cycle pulse: ld_data updated this cycle
misalign  output  1  one-cycle pulse: misaligned access detected, access dropped
dmem_req  output  1  memory request valid
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  addrWidth  word-aligned byte address (bits [1:0] = 0)
dmem_wdata  output  32  lane-replicated store data
dmem_wstrb  output  4  byte write strobes (0 for reads)
dmem_gnt  input  1  memory accepted request this cycle
dmem_rdata  input  32  read data word
dmem_rvalid  input  1  read data valid

Behaviour:
- Decode:
  - opcode 0000011: load; funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - opcode 0100011: store; funct3 000 SB, 001 SH, 010 SW.
  - Any other opcode/funct3 combination is a non-memory op: pass through with no stall and no request.
- Alignment:
  - off = alu_out[1:0].
  - Misaligned: halfword with off[0]=1, or word with off!=0.
  - On a misaligned op: misalign pulses for 1 cycle while state is IDLE, no request is issued, stall stays 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Aligned memory op present: stall=1 combinationally; latch op type, funct3, off, address, wdata, wstrb; next state REQ.
  - Otherwise stay in IDLE with stall=0.
- REQ:
  - dmem_req=1; addr/we/wdata/wstrb held stable until dmem_gnt.
  - Store + gnt: go to DONE.
  - Load + gnt + rvalid in the same cycle: capture rdata, go to DONE.
  - Load + gnt only: go to WAIT.
  - No gnt: stay in REQ.
- WAIT:
  - dmem_req=0.
  - rvalid: capture rdata, go to DONE.
  - Otherwise stay in WAIT (no timeout).
- DONE:
  - stall=0 so the pipeline advances on this edge.
  - ld_valid=1 for loads only; next state IDLE unconditionally.
  - Re-issue of the same instruction is prevented because the new instruction arrives with the IDLE cycle.
- Stall is 1 in REQ and WAIT, and in IDLE whenever an aligned memory op is present; 0 otherwise.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<off.
  - SH: wdata={2{rs2[15:0]}}, wstrb=4'b0011<<off.
  - SW: wdata=rs2, wstrb=4'b1111.
- Load extraction on capture:
  - Byte = rdata[8*off+:8]; halfword = rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - ld_data is registered and holds until the next load completes.
- dmem_addr = {alu_out[addrWidth-1:2], 2'b00}; upper address bits are ignored.
- Minimum latency with zero-wait memory:
  - Store: IDLE→REQ→DONE, 2 stall cycles.
  - Load: IDLE→REQ→WAIT→DONE, 3 stall cycles; 2 stall cycles if rvalid arrives with gnt.
- Reset:
  - Any state returns to IDLE.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0.
  - ld_data=0, ld_valid=0, misalign=0; stall follows IDLE decode of inst.
  - Reset mid-transaction abandons it; late gnt/rvalid arriving in IDLE are ignored.

Test Plan:
1. LW, alu_out=0x104, memory gnt immediate, rvalid next cycle, rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr=0x104, wstrb=0; ld_data=0xDEADBEEF with ld_valid pulse in DONE.
2. LB off=3, rdata=0x80123456 -> ld_data=0xFFFFFF80; LBU same -> 0x00000080; LHU off=2, rdata=0xBEEF0000 -> 0x0000BEEF.
3. SB rs2=0x000000A5, alu_out=0x202; gnt delayed 3 cycles -> req/addr=0x200/wdata=0xA5A5A5A5/wstrb=0100 stable until gnt, then DONE, stall released.
4. LH alu_out=0x101 -> misalign pulses 1 cycle, dmem_req never asserts, stall=0; ADD instruction -> no request, stall=0.
5. Load in WAIT, assert rst for 1 cycle, then rvalid arrives -> state IDLE, ld_valid never pulses, ld_data=0, dmem_req=0.
6. Back-to-back SW then LW with same address -> two separate transactions, no duplicate request, LW returns newly written word.
